// File: rtl/control_unit.sv
// control_unit: single-cycle instruction decoder with registered outputs.
//
// Each rising edge of clk samples command_code. alu_control_command,
// regwrite_control and illegal_opcode show the decode of that word one
// cycle later. The output registers are the only state.
//
// Interface timing: no handshake. A new command is accepted every cycle and
// the decoder never stalls, so there is no valid/ready pair.
//
// Optional feature: define CONTROL_UNIT_ILLEGAL_DETECT_EN to drive
// illegal_opcode high for reserved or unknown words. Without the macro the
// port is kept but tied to 0. Illegal words always decode to
// alu_control_command = 0x00 and regwrite_control = 0.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] command_code,
  output logic [7:0]  alu_control_command,
  output logic        regwrite_control,
  output logic        illegal_opcode
);

  typedef enum logic [7:0] {
    OP_NOP         = 8'h00,
    OP_ADD         = 8'h01,
    OP_SUB         = 8'h02,
    OP_MUL         = 8'h03,
    OP_AND         = 8'h04,
    OP_OR          = 8'h05,
    OP_NOT         = 8'h06,
    OP_XOR         = 8'h07,
    OP_LSHIFT      = 8'h08,
    OP_RSHIFT      = 8'h09,
    OP_GT          = 8'h0A,
    OP_LT          = 8'h0B,
    OP_EQ          = 8'h0C,
    OP_SET_COUNTER = 8'h0D,
    OP_INC_COUNTER = 8'h0E,
    OP_DEC_COUNTER = 8'h0F,
    OP_ADD_CARRY   = 8'h10
  } opcode_e;

  logic [7:0] alu_q, alu_d;
  logic       wr_q,  wr_d;
  logic       ill_q, ill_d;
  logic       reserved_nonzero;
  logic [7:0] opcode;
  logic       word_illegal;

  assign reserved_nonzero = |command_code[15:8];
  assign opcode           = command_code[7:0];

  // Decode the sampled word into the next output values.
  always_comb begin
    alu_d        = 8'h00;
    wr_d         = 1'b0;
    word_illegal = 1'b0;
    if (reserved_nonzero) begin
      word_illegal = 1'b1;
    end else begin
      case (opcode)
        OP_NOP: begin
          alu_d = 8'h00;
          wr_d  = 1'b0;
        end
        // Register-writing ALU operations.
        OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_NOT, OP_XOR,
        OP_LSHIFT, OP_RSHIFT, OP_ADD_CARRY: begin
          alu_d = opcode;
          wr_d  = 1'b1;
        end
        // Compares and counter ops update flag or counter state only.
        OP_GT, OP_LT, OP_EQ,
        OP_SET_COUNTER, OP_INC_COUNTER, OP_DEC_COUNTER: begin
          alu_d = opcode;
          wr_d  = 1'b0;
        end
        default: begin
          word_illegal = 1'b1;
        end
      endcase
    end
`ifdef CONTROL_UNIT_ILLEGAL_DETECT_EN
    ill_d = word_illegal;
`else
    ill_d = 1'b0;
`endif
  end

  // Output registers. Reset drops any in-flight decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q <= 8'h00;
      wr_q  <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      alu_q <= alu_d;
      wr_q  <= wr_d;
      ill_q <= ill_d;
    end
  end

  assign alu_control_command = alu_q;
  assign regwrite_control    = wr_q;
  assign illegal_opcode      = ill_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and random checks of control_unit against a
// rule-based reference model. Build with CONTROL_UNIT_ILLEGAL_DETECT_EN
// defined or undefined; the model follows the same macro.
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic [15:0] command_code;
  logic [7:0]  alu_control_command;
  logic        regwrite_control;
  logic        illegal_opcode;

  int n_checks = 0;
  int n_errors = 0;

  // Each entry is {illegal, regwrite, alu[7:0]}.
  logic [9:0] exp_q[$];

  control_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .command_code        (command_code),
    .alu_control_command (alu_control_command),
    .regwrite_control    (regwrite_control),
    .illegal_opcode      (illegal_opcode)
  );

  // Clock and reset defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst          = 1'b1;
    command_code = 16'h0000;
  end

`ifdef CONTROL_UNIT_ILLEGAL_DETECT_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  // Reference model. The word is legal when the upper byte is zero and the
  // opcode lies in 1..16. Opcodes 10..15 do not write the register file.
  function automatic logic [9:0] model(input logic r, input logic [15:0] c);
    int  op;
    bit  legal;
    bit  nop;
    bit  wr;
    bit  ill;
    int  alu;
    if (r) return 10'd0;
    op    = int'(c[7:0]);
    nop   = (c == 16'h0000);
    legal = (c[15:8] == 8'h00) && (op >= 1) && (op <= 16);
    alu   = legal ? op : 0;
    wr    = legal && !(op >= 10 && op <= 15);
    ill   = ILL_EN && !legal && !nop;
    return {ill, wr, 8'(alu)};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one command, then compare outputs just after the capturing edge.
  task automatic step(input logic r, input logic [15:0] c, input string tag);
    logic [9:0] e;
    @(negedge clk);
    rst          = r;
    command_code = c;
    exp_q.push_back(model(r, c));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq({tag, ".alu"}, {8'h00, alu_control_command}, {8'h00, e[7:0]});
    check_eq({tag, ".wr"},  {15'h0, regwrite_control},    {15'h0, e[8]});
    check_eq({tag, ".ill"}, {15'h0, illegal_opcode},      {15'h0, e[9]});
  endtask

  initial begin
    logic [15:0] c;
    logic        r;
    int          sel;

    // Reset held for two cycles with a legal word present.
    step(1'b1, 16'h0001, "reset0");
    step(1'b1, 16'h0001, "reset1");
    step(1'b0, 16'h0001, "post_reset");

    // Full legal sweep.
    for (int i = 1; i <= 16; i++) step(1'b0, 16'(i), "sweep");

    // NOP and illegal words.
    step(1'b0, 16'h0000, "nop");
    step(1'b0, 16'h0011, "illegal_0011");
    step(1'b0, 16'h0103, "illegal_0103");
    step(1'b0, 16'h00FF, "illegal_00ff");
    step(1'b0, 16'h0000, "nop_after_illegal");

    // Back-to-back mixed commands.
    step(1'b0, 16'h0003, "b2b0");
    step(1'b0, 16'h000B, "b2b1");
    step(1'b0, 16'h0010, "b2b2");

    // Reset pulse in the middle of a stream.
    step(1'b0, 16'h0007, "mid_pre");
    step(1'b1, 16'h0007, "mid_rst");
    step(1'b0, 16'h0007, "mid_post");

    // Random traffic biased toward legal opcodes.
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)       c = 16'($urandom_range(1, 16));
      else if (sel < 7)  c = 16'($urandom_range(0, 255));
      else if (sel < 8)  c = 16'h0000;
      else               c = 16'($urandom);
      r = ($urandom_range(0, 19) == 0);
      step(r, c, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
